// File: rtl/t_reg_bank.sv
// t_reg_bank: parallel-load register chain drained one word per handshake
// from stage 0, with serial fill at the tail stage.
// The optional recirculating mode is selected by the macro
// T_REG_BANK_ROTATE_EN: the tail stage takes the outgoing stage-0 word
// instead of sh_in. Without the macro the tail is filled from sh_in.
module t_reg_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          ld_valid,
  input  logic [DEPTH*DATA_WIDTH-1:0]   ld_data,
  output logic                          ld_ready,
  input  logic [DATA_WIDTH-1:0]         sh_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] stage_q [DEPTH];
  logic [DATA_WIDTH-1:0] stage_d [DEPTH];

  logic is_drain;
  logic is_last;
  logic do_load;
  logic do_shift;

  assign is_drain = (state_q == ST_DRAIN);
  assign is_last  = is_drain && (count_q == CNT_ONE);

  // A new burst can be taken while idle, or in the same cycle the final
  // word of the current burst leaves, so bursts can run back to back.
  assign ld_ready = !is_drain || (is_last && m_ready);

  // Load wins over shift; both are gated by the global enable.
  assign do_load  = en && ld_valid && ld_ready;
  assign do_shift = en && is_drain && m_ready && !do_load;

  assign m_valid = is_drain;
  assign m_last  = is_last;
  assign m_data  = stage_q[0];
  assign count   = count_q;

  // Per-stage next value: parallel word on load, neighbour (or tail fill) on shift.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [DATA_WIDTH-1:0] shift_src;
      if (gi == DEPTH-1) begin : g_tail
`ifdef T_REG_BANK_ROTATE_EN
        assign shift_src = stage_q[0];
`else
        assign shift_src = sh_in;
`endif
      end else begin : g_body
        assign shift_src = stage_q[gi+1];
      end
      assign stage_d[gi] = do_load  ? ld_data[gi*DATA_WIDTH +: DATA_WIDTH] :
                           do_shift ? shift_src : stage_q[gi];
    end
  endgenerate

  // Next-state and remaining-word count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (do_load) begin
      state_d = ST_DRAIN;
      count_d = CNT_FULL;
    end else if (do_shift) begin
      count_d = count_q - CNT_ONE;
      if (is_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State registers; reset clears everything, even mid-burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

endmodule

// File: tb/tb_t_reg_bank.sv
// Testbench for t_reg_bank (DATA_WIDTH=16, DEPTH=4): directed vector table,
// a few hand sequences, then randomized traffic against a queue-based model.
module tb_t_reg_bank;

  localparam int DW = 16;
  localparam int DP = 4;

`ifdef T_REG_BANK_ROTATE_EN
  localparam bit ROT = 1'b1;
  localparam logic [15:0] R6_DATA = 16'h0011;
`else
  localparam bit ROT = 1'b0;
  localparam logic [15:0] R6_DATA = 16'hAAAA;
`endif

  logic            clk = 1'b0;
  logic            rst, en, ld_valid, m_ready;
  logic [DP*DW-1:0] ld_data;
  logic [DW-1:0]   sh_in;
  logic            ld_ready, m_valid, m_last;
  logic [DW-1:0]   m_data;
  logic [2:0]      count;

  int n_checks = 0;
  int n_fail   = 0;

  t_reg_bank #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .en(en), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .sh_in(sh_in), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: the bank is a queue of words plus a remaining count.
  logic [15:0] mq[$];
  int          mcnt;

  function automatic logic model_ldr();
    return (mcnt == 0) || (mcnt == 1 && m_ready);
  endfunction

  task automatic model_step();
    logic [15:0] old;
    if (rst) begin
      for (int i = 0; i < DP; i++) mq[i] = '0;
      mcnt = 0;
    end else if (en) begin
      if (ld_valid && model_ldr()) begin
        for (int i = 0; i < DP; i++) mq[i] = ld_data[i*DW +: DW];
        mcnt = DP;
      end else if (mcnt > 0 && m_ready) begin
        old = mq.pop_front();
        mq.push_back(ROT ? old : sh_in);
        mcnt--;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic chk_outs(input string tag, input logic mv, input logic [15:0] md,
                          input logic ml, input logic [2:0] cnt, input logic ldr);
    chk({tag, ".m_valid"},  32'(m_valid),  32'(mv));
    chk({tag, ".m_data"},   32'(m_data),   32'(md));
    chk({tag, ".m_last"},   32'(m_last),   32'(ml));
    chk({tag, ".count"},    32'(count),    32'(cnt));
    chk({tag, ".ld_ready"}, 32'(ld_ready), 32'(ldr));
  endtask

  task automatic chk_model(input string tag);
    chk_outs(tag, mcnt > 0, mq[0], mcnt == 1, 3'(mcnt), model_ldr());
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic e, input logic lv, input logic mr,
                       input logic [63:0] ld, input logic [15:0] sh);
    rst = r; en = e; ld_valid = lv; m_ready = mr; ld_data = ld; sh_in = sh;
  endtask

  typedef struct {
    logic        rst, en, lv, mr;
    logic [63:0] ld;
    logic [15:0] sh;
    logic        mv;
    logic [15:0] md;
    logic        ml;
    logic [2:0]  cnt;
    logic        ldr;
  } vec_t;

  localparam logic [63:0] LD = 64'h0044_0033_0022_0011;
  localparam logic [63:0] BB = 64'h0008_0007_0006_0005;
  localparam logic [15:0] AA = 16'hAAAA;

  vec_t tbl[21];

  initial begin
    mq = '{16'h0, 16'h0, 16'h0, 16'h0};
    mcnt = 0;
    drive(1, 1, 0, 0, '0, '0);
    step();

    // {rst,en,lv,mr,ld,sh, expected mv,md,ml,count,ld_ready before the edge}
    tbl[0]  = '{1,0,0,0,LD,AA, 0,16'h0000,0,0,1};   // reset state, rst beats en=0
    tbl[1]  = '{0,1,1,1,LD,AA, 0,16'h0000,0,0,1};   // load
    tbl[2]  = '{0,1,0,1,64'h0,AA, 1,16'h0011,0,4,0};
    tbl[3]  = '{0,1,0,1,64'h0,AA, 1,16'h0022,0,3,0};
    tbl[4]  = '{0,1,0,1,64'h0,AA, 1,16'h0033,0,2,0};
    tbl[5]  = '{0,1,0,1,64'h0,AA, 1,16'h0044,1,1,1};
    tbl[6]  = '{0,1,1,0,LD,AA, 0,R6_DATA,0,0,1};    // idle, reload
    tbl[7]  = '{0,1,0,0,64'h0,AA, 1,16'h0011,0,4,0}; // backpressure
    tbl[8]  = '{0,1,0,0,64'h0,AA, 1,16'h0011,0,4,0};
    tbl[9]  = '{0,1,0,0,64'h0,AA, 1,16'h0011,0,4,0};
    tbl[10] = '{0,1,0,1,64'h0,AA, 1,16'h0011,0,4,0};
    tbl[11] = '{0,1,1,0,BB,AA, 1,16'h0022,0,3,0};    // load ignored mid-burst
    tbl[12] = '{0,1,1,1,BB,AA, 1,16'h0022,0,3,0};
    tbl[13] = '{0,1,0,1,64'h0,AA, 1,16'h0033,0,2,0};
    tbl[14] = '{0,1,1,1,BB,AA, 1,16'h0044,1,1,1};    // back-to-back load
    tbl[15] = '{0,0,1,1,LD,AA, 1,16'h0005,0,4,0};    // en=0 freeze
    tbl[16] = '{0,0,0,0,LD,AA, 1,16'h0005,0,4,0};
    tbl[17] = '{0,1,0,1,64'h0,AA, 1,16'h0005,0,4,0};
    tbl[18] = '{0,1,0,1,64'h0,AA, 1,16'h0006,0,3,0};
    tbl[19] = '{1,1,0,1,64'h0,AA, 1,16'h0007,0,2,0}; // reset mid-burst
    tbl[20] = '{0,0,0,0,64'h0,AA, 0,16'h0000,0,0,1};

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].lv, tbl[i].mr, tbl[i].ld, tbl[i].sh);
      #1;
      $display("vec %0d: m_valid=%0b m_data=%h m_last=%0b count=%0d ld_ready=%0b",
               i, m_valid, m_data, m_last, count, ld_ready);
      chk_outs($sformatf("vec%0d", i), tbl[i].mv, tbl[i].md, tbl[i].ml, tbl[i].cnt, tbl[i].ldr);
      step();
    end

    // Hand sequence: en=0 in IDLE blocks a load request.
    drive(0, 0, 1, 1, LD, AA);
    step();
    #1;
    $display("hand idle-freeze: m_valid=%0b count=%0d", m_valid, count);
    chk_outs("idle_freeze", 0, 16'h0000, 0, 0, 1);

    // Hand sequence: one-cycle load latency, word 0 visible.
    drive(0, 1, 1, 0, 64'h0004_0003_0002_0001, AA);
    step();
    drive(0, 1, 0, 0, '0, AA);
    #1;
    $display("hand latency: m_valid=%0b m_data=%h count=%0d", m_valid, m_data, count);
    chk_outs("latency", 1, 16'h0001, 0, 4, 0);

`ifdef T_REG_BANK_ROTATE_EN
    // Recirculation: after four accepts the burst is back in place.
    for (int k = 0; k < DP; k++) begin
      drive(0, 1, 0, 1, '0, AA);
      #1;
      $display("hand rotate %0d: m_data=%h", k, m_data);
      chk($sformatf("rotate%0d", k), 32'(m_data), 32'(k + 1));
      step();
    end
    #1;
    chk("rotate_wrap", 32'(m_data), 32'h1);
`endif

    // Randomized traffic against the model.
    drive(1, 1, 0, 0, '0, '0);
    step();
    for (int c = 0; c < 300; c++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
            {$urandom, $urandom}, 16'($urandom));
      #1;
      $display("rnd %0d: rst=%0b en=%0b lv=%0b mr=%0b m_data=%h count=%0d",
               c, rst, en, ld_valid, m_ready, m_data, count);
      chk_model($sformatf("rnd%0d", c));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/t_reg_bank.md
T_REG_BANK -- requirements
Module: t_reg_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 16: bit width of one stage word.
REQ-002 Parameter DEPTH, default 4 (legal range 2..64): number of stages in the chain.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 en  input  1  global clock enable; when 0, all state holds.
REQ-006 ld_valid  input  1  parallel store request.
REQ-007 ld_data  input  DEPTH*DATA_WIDTH  store words; word i is ld_data[i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ld_ready  output  1  bank can accept a parallel store.
REQ-009 sh_in  input  DATA_WIDTH  serial fill word, entering stage DEPTH-1 on each shift.
REQ-010 m_valid  output  1  m_data holds a valid word.
REQ-011 m_ready  input  1  downstream accepts m_data.
REQ-012 m_data  output  DATA_WIDTH  current content of stage 0.
REQ-013 m_last  output  1  current word is the final word of the burst.
REQ-014 count  output  clog2(DEPTH+1)  words remaining in the current burst.

Function
REQ-015 The bank SHALL implement a two-state FSM: IDLE and DRAIN.
REQ-016 In IDLE, ld_ready SHALL be 1, m_valid SHALL be 0, and the stages SHALL hold.
REQ-017 In IDLE, a cycle with en=1 and ld_valid=1 SHALL store word i into stage i for every i, SHALL set count to DEPTH, and SHALL enter DRAIN.
REQ-018 In DRAIN, m_valid SHALL be 1 and ld_ready SHALL be 0; ld_valid SHALL be ignored except in the case of REQ-021.
REQ-019 In DRAIN, a cycle with en=1, m_valid=1 and m_ready=1 SHALL perform a shift:
  - stage i takes stage i+1;
  - stage DEPTH-1 takes sh_in;
  - count decrements by 1.
REQ-020 In DRAIN, m_last SHALL equal (count==1); in IDLE, m_last SHALL be 0.
REQ-021 On the cycle the last word is accepted (count==1):
  - ld_ready SHALL be 1 combinationally;
  - if ld_valid=1, the parallel store SHALL take priority over the shift, the FSM SHALL stay in DRAIN, and count SHALL be DEPTH (back-to-back bursts without a bubble);
  - otherwise the shift SHALL occur and the FSM SHALL enter IDLE.
REQ-022 A DRAIN cycle with m_ready=0 SHALL hold m_data, count and state unchanged.
REQ-023 en=0 SHALL freeze the stages, count and state, regardless of ld_valid or m_ready; outputs SHALL stay combinational functions of the held state.
REQ-024 The latency from an accepted ld_valid to m_valid=1 SHALL be exactly 1 cycle, with m_data equal to word 0.

Reset
REQ-025 When rst=1 at a clock edge, the following SHALL hold, taking priority over en and every other input, including mid-burst:
  - every stage = 0;
  - count = 0;
  - FSM = IDLE.
REQ-026 After reset, the outputs SHALL be ld_ready=1, m_valid=0, m_data=0, m_last=0, count=0.

Configuration
REQ-027 Macro T_REG_BANK_ROTATE_EN, when defined, SHALL make stage DEPTH-1 take the outgoing stage 0 word on each shift, so the burst recirculates; sh_in SHALL be ignored.
REQ-028 Without T_REG_BANK_ROTATE_EN, stage DEPTH-1 SHALL take sh_in on each shift, per REQ-019.

Verification (DATA_WIDTH=16, DEPTH=4)
REQ-029 Load test: load words {0x0011,0x0022,0x0033,0x0044} with m_ready=1 and sh_in=0xAAAA -> m_data is 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles, m_last=1 only on 0x0044, then IDLE with m_data=0xAAAA.
REQ-030 Backpressure test: hold m_ready=0 for 3 cycles after the load -> m_data stays 0x0011 and count stays 4; on release, the sequence resumes unchanged.
REQ-031 Back-to-back test: assert ld_valid with {5,6,7,8} during the 0x0044 accept cycle -> the next cycle shows m_data=5, count=4, with no m_valid gap.
REQ-032 Stall and reset test:
  - toggle en=0 mid-burst -> no state change;
  - assert rst after 2 words -> next cycle count=0, m_valid=0, m_data=0, ld_ready=1.
REQ-033 Rotate test: with T_REG_BANK_ROTATE_EN defined, after 4 accepts of {1,2,3,4} -> the stages again hold {1,2,3,4}.
REQ-034 Load-ignored test: assert ld_valid mid-burst (count=3) -> ld_ready=0 and the stage contents are unaffected.
